// File: rtl/multi_button_counter.sv
// multi_button_counter
//   Three debounced push-buttons (up, down, clear) driving an up/down counter of
//   NUM_DIGITS 4-bit digits, BCD ("DEC") or binary ("HEX"), with optional
//   auto-repeat on up/down, leading-zero blanking and a sticky wrap flag.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   btn_up       raw asynchronous button, increment
//   btn_down     raw asynchronous button, decrement
//   btn_clr      raw asynchronous button, clear count and wrap flag
//   encoded      count, digit i at [4i+3:4i], digit 0 least significant
//   digit_blank  1 = digit should be unlit
//   wrapped      sticky wrap-around flag, cleared by clr or reset
//   count_upd    one-cycle pulse in the cycle encoded changes

// mbc_debounce
//   Two-flop synchroniser plus debounce/auto-repeat FSM for one button.
//   Emits a one-cycle pulse on an accepted press and on each auto-repeat.
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   btn         raw asynchronous button
//   pulse       registered one-cycle press/repeat pulse
//
// state  | meaning
// IDLE   | button released, waiting for a synchronised high
// QUAL_H | qualifying a press, cnt = consecutive high samples
// HELD   | press accepted, cnt times auto-repeat while held
// QUAL_L | qualifying a release, cnt = consecutive low samples
module mbc_debounce #(
  parameter int DEBOUNCE_CYCLES = 256,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 0,
  parameter int CNT_W           = 9,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  typedef enum logic [1:0] {IDLE, QUAL_H, HELD, QUAL_L} state_t;

  localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DEBOUNCE_CYCLES);
  // Repeat compares are one less than the nominal interval because cnt is
  // cleared in the same edge that emits the previous pulse.
  localparam logic [CNT_W-1:0] RD_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_TC = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state;
  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic             rep_phase;  // 0 = waiting initial delay, 1 = periodic

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      cnt       <= '0;
      rep_phase <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      pulse   <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q2) begin
            state <= QUAL_H;
            cnt   <= CNT_W'(1);
          end
        end
        QUAL_H: begin
          if (!sync_q2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_TC) begin
            state     <= HELD;
            pulse     <= 1'b1;
            cnt       <= '0;
            rep_phase <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!sync_q2) begin
            state <= QUAL_L;
            cnt   <= CNT_W'(1);
          end else if (REPEAT_EN) begin
            if ((!rep_phase && cnt == RD_TC) || (rep_phase && cnt == RP_TC)) begin
              pulse     <= 1'b1;
              cnt       <= '0;
              rep_phase <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        QUAL_L: begin
          if (sync_q2) begin
            // Bounce back to held: repeat timing restarts, no extra pulse.
            state     <= HELD;
            cnt       <= '0;
            rep_phase <= 1'b0;
          end else if (cnt == DB_TC) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

module multi_button_counter #(
  parameter int NUM_DIGITS      = 8,
  parameter     MODE            = "DEC",
  parameter int DEBOUNCE_CYCLES = 256,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 0,
  parameter int BLANK_LEADING   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_clr,
  output logic [NUM_DIGITS*4-1:0] encoded,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    wrapped,
  output logic                    count_upd
);

  localparam int W        = NUM_DIGITS * 4;
  localparam bit IS_HEX   = (MODE == "HEX");
  localparam int MAX_DR   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX  = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam bit RPT_EN   = (REPEAT_DELAY > 0);
  // Count of zero: every digit above digit 0 blanked when blanking is on.
  localparam logic [NUM_DIGITS-1:0] RST_BLANK =
    (BLANK_LEADING != 0) ? ~NUM_DIGITS'(1) : '0;

  logic up_p, down_p, clr_p;

  mbc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W), .REPEAT_EN(RPT_EN)
  ) u_db_up (.clk(clk), .reset(reset), .btn(btn_up), .pulse(up_p));

  mbc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W), .REPEAT_EN(RPT_EN)
  ) u_db_down (.clk(clk), .reset(reset), .btn(btn_down), .pulse(down_p));

  // Clear never auto-repeats.
  mbc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W), .REPEAT_EN(1'b0)
  ) u_db_clr (.clk(clk), .reset(reset), .btn(btn_clr), .pulse(clr_p));

  logic [W-1:0]          inc_val, dec_val, nxt_enc;
  logic [NUM_DIGITS-1:0] nxt_blank;
  logic                  carry, borrow, nxt_wrap, nxt_upd, zero_above;
  logic [3:0]            dig;

  // Incremented/decremented candidates. After the loop carry/borrow are set
  // only if every digit rippled, i.e. the operation wraps.
  always_comb begin
    inc_val = encoded;
    dec_val = encoded;
    carry   = 1'b1;
    borrow  = 1'b1;
    dig     = '0;
    if (IS_HEX) begin
      inc_val = encoded + W'(1);
      dec_val = encoded - W'(1);
      carry   = &encoded;
      borrow  = (encoded == '0);
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig = encoded[4*i +: 4];
        if (carry) begin
          if (dig == 4'd9) begin
            inc_val[4*i +: 4] = 4'd0;
          end else begin
            inc_val[4*i +: 4] = dig + 4'd1;
            carry = 1'b0;
          end
        end
        if (borrow) begin
          if (dig == 4'd0) begin
            dec_val[4*i +: 4] = 4'd9;
          end else begin
            dec_val[4*i +: 4] = dig - 4'd1;
            borrow = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    nxt_enc  = encoded;
    nxt_wrap = wrapped;
    nxt_upd  = 1'b0;
    if (clr_p) begin
      nxt_enc  = '0;
      nxt_wrap = 1'b0;
      nxt_upd  = 1'b1;
    end else if (up_p && down_p) begin
      nxt_upd = 1'b0;
    end else if (up_p) begin
      nxt_enc  = inc_val;
      nxt_wrap = wrapped | carry;
      nxt_upd  = 1'b1;
    end else if (down_p) begin
      nxt_enc  = dec_val;
      nxt_wrap = wrapped | borrow;
      nxt_upd  = 1'b1;
    end
  end

  // Blank digit i when it and every digit above it are zero; digit 0 stays lit.
  always_comb begin
    nxt_blank  = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (nxt_enc[4*i +: 4] == 4'd0);
      nxt_blank[i] = (BLANK_LEADING != 0) && zero_above;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      encoded     <= '0;
      digit_blank <= RST_BLANK;
      wrapped     <= 1'b0;
      count_upd   <= 1'b0;
    end else begin
      encoded     <= nxt_enc;
      digit_blank <= nxt_blank;
      wrapped     <= nxt_wrap;
      count_upd   <= nxt_upd;
    end
  end

endmodule
